// File: rtl/storage_arb_pkg.sv
// Shared types and helpers for storage_arbiter: storage modes, op codes,
// FSM state encoding and the mode-to-chip-enable decode.
package storage_arb_pkg;

    typedef enum logic [1:0] {
        MODE_FIFO = 2'd0,
        MODE_LIFO = 2'd1,
        MODE_BUF  = 2'd2
    } mode_t;

    // Code 3 has no storage behind it; it is refused before any access.
    localparam logic [1:0] MODE_ILLEGAL = 2'd3;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Returns {en_buffer, en_lifo, en_fifo}; st_mode never holds the illegal code.
    function automatic logic [2:0] mode_to_en(input logic [1:0] m);
        case (m)
            MODE_LIFO: mode_to_en = 3'b010;
            MODE_BUF:  mode_to_en = 3'b100;
            default:   mode_to_en = 3'b001;
        endcase
    endfunction

endpackage

// File: rtl/storage_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick; searches upward from last+1
// with wrap and returns the winner as one-hot and as an index.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        found   = 1'b0;
        cand    = '0;
        gnt_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_oh = found ? (N'(1) << gnt_idx) : '0;
    end

    assign any = |req;

endmodule

// File: rtl/storage_arbiter.sv
// storage_arbiter: shares one mode-selectable storage block between N_REQ
// requesters, one operation at a time. Define STORAGE_ARB_OCC_EN to add occ.
module storage_arbiter
    import storage_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      op,
    input  logic [2*N_REQ-1:0]    mode_req,
    input  logic [DW*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic [DW-1:0]         rdata,
    output logic [1:0]            st_mode,
    output logic                  st_en_fifo,
    output logic                  st_en_lifo,
    output logic                  st_en_buffer,
    output logic [DW-1:0]         st_din,
    output logic                  st_push,
    output logic                  st_pop,
    input  logic                  st_empty,
    input  logic                  st_full,
    input  logic [DW-1:0]         st_dout,
`ifdef STORAGE_ARB_OCC_EN
    output logic [$clog2(DEPTH):0] occ,
`endif
    output logic [2:0]            dbg_state
);

    // Handshake: req[i] is a level held until done[i]; gnt[i] pulses once in
    // CHECK when the request is taken, done[i] pulses once in DONE with err[i]
    // qualifying it; rdata is meaningful only with done of a successful pop.

    localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int OCW = $clog2(DEPTH) + 1;

    localparam logic [2:0] ST_IDLE    = S_IDLE;
    localparam logic [2:0] ST_CHECK   = S_CHECK;
    localparam logic [2:0] ST_ISSUE   = S_ISSUE;
    localparam logic [2:0] ST_CAPTURE = S_CAPTURE;
    localparam logic [2:0] ST_DONE    = S_DONE;

    logic [2:0]       state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    last;
    logic [IW-1:0]    arb_idx;
    logic [N_REQ-1:0] arb_oh;
    logic             arb_any;
    logic [N_REQ-1:0] idx_oh;
    logic             op_l;
    logic [1:0]       mode_l;
    logic [DW-1:0]    wdata_l;
    logic             reject;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req     (req),
        .last    (last),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    assign idx_oh    = N_REQ'(1) << idx;
    assign dbg_state = state;
    assign {st_en_buffer, st_en_lifo, st_en_fifo} = mode_to_en(st_mode);

    // A mode switch is only allowed on empty storage so no data changes order.
    always_comb begin
        reject = 1'b0;
        if (mode_l == MODE_ILLEGAL)
            reject = 1'b1;
        if (op_l == OP_PUSH && st_full)
            reject = 1'b1;
        if (op_l == OP_POP && st_empty)
            reject = 1'b1;
        if (mode_l != st_mode && !st_empty)
            reject = 1'b1;
`ifdef STORAGE_ARB_OCC_EN
        if (op_l == OP_PUSH && occ == OCW'(DEPTH))
            reject = 1'b1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            last    <= IW'(N_REQ - 1);
            op_l    <= OP_PUSH;
            mode_l  <= MODE_FIFO;
            wdata_l <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rdata   <= '0;
            st_mode <= MODE_FIFO;
            st_din  <= '0;
            st_push <= 1'b0;
            st_pop  <= 1'b0;
        end else begin
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            st_push <= 1'b0;
            st_pop  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        idx     <= arb_idx;
                        last    <= arb_idx;
                        op_l    <= op[arb_idx];
                        mode_l  <= mode_req[arb_idx*2 +: 2];
                        wdata_l <= wdata[arb_idx*DW +: DW];
                        gnt     <= arb_oh;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (reject) begin
                        done  <= idx_oh;
                        err   <= idx_oh;
                        state <= ST_DONE;
                    end else begin
                        st_mode <= mode_l;
                        if (op_l == OP_POP) begin
                            st_pop <= 1'b1;
                        end else begin
                            st_push <= 1'b1;
                            st_din  <= wdata_l;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (op_l == OP_POP) begin
                        state <= ST_CAPTURE;
                    end else begin
                        done  <= idx_oh;
                        state <= ST_DONE;
                    end
                end
                ST_CAPTURE: begin
                    rdata <= st_dout;
                    done  <= idx_oh;
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef STORAGE_ARB_OCC_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ <= '0;
        end else if (st_push && occ != OCW'(DEPTH)) begin
            occ <= occ + 1'b1;
        end else if (st_pop && occ != '0) begin
            occ <= occ - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_storage_arbiter.sv
// Bench for storage_arbiter: behavioural FIFO/LIFO storage, directed driver
// tasks and a done/gnt scoreboard consumed by an independent monitor.
module tb_storage_arbiter;

    localparam int N_REQ = 3;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int W     = 12;  // {idx[1:0], err, chk_rdata, rdata[7:0]}

    logic                clk;
    logic                reset;
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    op;
    logic [2*N_REQ-1:0]  mode_req;
    logic [DW*N_REQ-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    done;
    logic [N_REQ-1:0]    err;
    logic [DW-1:0]       rdata;
    logic [1:0]          st_mode;
    logic                st_en_fifo;
    logic                st_en_lifo;
    logic                st_en_buffer;
    logic [DW-1:0]       st_din;
    logic                st_push;
    logic                st_pop;
    logic                st_empty;
    logic                st_full;
    logic [DW-1:0]       st_dout;
    logic [2:0]          dbg_state;
`ifdef STORAGE_ARB_OCC_EN
    logic [3:0]          occ;
`endif

    logic [W-1:0] exp_q[$];
    logic [1:0]   gnt_q[$];
    logic [DW-1:0] store_q[$];
    int st_cnt;
    int total;
    int bad;
    int push_cnt;
    int pop_cnt;

    storage_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .op           (op),
        .mode_req     (mode_req),
        .wdata        (wdata),
        .gnt          (gnt),
        .done         (done),
        .err          (err),
        .rdata        (rdata),
        .st_mode      (st_mode),
        .st_en_fifo   (st_en_fifo),
        .st_en_lifo   (st_en_lifo),
        .st_en_buffer (st_en_buffer),
        .st_din       (st_din),
        .st_push      (st_push),
        .st_pop       (st_pop),
        .st_empty     (st_empty),
        .st_full      (st_full),
        .st_dout      (st_dout),
`ifdef STORAGE_ARB_OCC_EN
        .occ          (occ),
`endif
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // behavioural storage: buffer mode behaves like FIFO order
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_q.delete();
            st_dout <= '0;
            st_cnt  <= 0;
        end else begin
            if (st_push && store_q.size() < DEPTH)
                store_q.push_back(st_din);
            if (st_pop && store_q.size() > 0) begin
                if (st_mode == 2'd1) st_dout <= store_q.pop_back();
                else                 st_dout <= store_q.pop_front();
            end
            st_cnt <= store_q.size();
        end
    end

    assign st_empty = (st_cnt == 0);
    assign st_full  = (st_cnt == DEPTH);

    function automatic logic [N_REQ-1:0] oh(input logic [1:0] i);
        oh = 3'b001 << i;
    endfunction

    function automatic logic [2:0] exp_en(input logic [1:0] m);
        case (m)
            2'd0:    exp_en = 3'b001;
            2'd1:    exp_en = 3'b010;
            2'd2:    exp_en = 3'b100;
            default: exp_en = 3'b000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // one operation from requester r; expected response goes to the scoreboard
    task automatic do_op(input int r, input logic o, input logic [1:0] m, input logic [7:0] d,
                         input logic e_err, input logic [7:0] e_rd, input int e_lat);
        int n;
        exp_q.push_back({2'(r), e_err, (o && !e_err), e_rd});
        gnt_q.push_back(2'(r));
        @(negedge clk);
        op[r] = o;
        mode_req[r*2 +: 2] = m;
        wdata[r*DW +: DW] = d;
        req[r] = 1'b1;
        n = 0;
        while (!done[r] && n < 20) begin
            @(negedge clk);
            n++;
        end
        req[r] = 1'b0;
        check("latency", 32'(n + 1), 32'(e_lat));
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic [W-1:0] e;
        logic [1:0]   g;
        int cyc;
        int last_strobe;
        cyc = 0;
        last_strobe = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset && done != '0) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_idx", 32'(done), 32'(oh(e[11:10])));
                    check("err", 32'(err), e[9] ? 32'(oh(e[11:10])) : 32'd0);
                    if (e[8]) check("rdata", 32'(rdata), 32'(e[7:0]));
                end
            end
            if (reset && gnt != '0) begin
                if (gnt_q.size() == 0) begin
                    check("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    g = gnt_q.pop_front();
                    check("gnt_order", 32'(gnt), 32'(oh(g)));
                end
            end
            if (st_push || st_pop) begin
                check("strobe_spacing", 32'(cyc - last_strobe >= 4), 32'd1);
                check("strobe_excl", 32'(st_push & st_pop), 32'd0);
                check("en_onehot", 32'({st_en_buffer, st_en_lifo, st_en_fifo}), 32'(exp_en(st_mode)));
                last_strobe = cyc;
                if (st_push) push_cnt++;
                if (st_pop)  pop_cnt++;
            end
        end
    end

    // directed stimulus
    initial begin
        int snap;
        int n;
        int cnt0;
        total = 0; bad = 0; push_cnt = 0; pop_cnt = 0;
        reset = 1'b0; req = '0; op = '0; mode_req = '0; wdata = '0;
        repeat (3) @(negedge clk);

        check("rst_gnt",   32'(gnt), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_strb",  32'({st_push, st_pop}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_din",   32'(st_din), 32'd0);
        check("rst_mode",  32'(st_mode), 32'd0);
        check("rst_en",    32'({st_en_buffer, st_en_lifo, st_en_fifo}), 32'b001);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b1;

        // FIFO: push 11/22/33 from req0, pop from req1
        for (int i = 0; i < 3; i++)
            do_op(0, 1'b0, 2'd0, 8'(8'h11 * (i + 1)), 1'b0, 8'h00, 4);
        for (int i = 0; i < 3; i++)
            do_op(1, 1'b1, 2'd0, 8'h00, 1'b0, 8'(8'h11 * (i + 1)), 5);

        // LIFO on empty storage
        do_op(0, 1'b0, 2'd1, 8'h11, 1'b0, 8'h00, 4);
        check("lifo_mode", 32'(st_mode), 32'd1);
        check("lifo_en", 32'({st_en_buffer, st_en_lifo, st_en_fifo}), 32'b010);
        do_op(0, 1'b0, 2'd1, 8'h22, 1'b0, 8'h00, 4);
        do_op(0, 1'b0, 2'd1, 8'h33, 1'b0, 8'h00, 4);
        for (int i = 0; i < 3; i++)
            do_op(1, 1'b1, 2'd1, 8'h00, 1'b0, 8'(8'h11 * (3 - i)), 5);

        // pop on empty storage
        snap = pop_cnt;
        do_op(1, 1'b1, 2'd1, 8'h00, 1'b1, 8'h00, 3);
        check("empty_no_pop", 32'(pop_cnt - snap), 32'd0);

        // overflow: DEPTH+1 pushes
        snap = push_cnt;
        for (int i = 0; i < DEPTH; i++)
            do_op(2, 1'b0, 2'd0, 8'(8'hA0 + i), 1'b0, 8'h00, 4);
        do_op(2, 1'b0, 2'd0, 8'hEE, 1'b1, 8'h00, 3);
        check("full_push_cnt", 32'(push_cnt - snap), 32'(DEPTH));
`ifdef STORAGE_ARB_OCC_EN
        check("occ_full", 32'(occ), 32'(DEPTH));
`endif

        // mode change to buffer while non-empty
        snap = pop_cnt;
        do_op(1, 1'b1, 2'd2, 8'h00, 1'b1, 8'h00, 3);
        check("bufmode_kept", 32'(st_mode), 32'd0);
        check("bufmode_no_pop", 32'(pop_cnt - snap), 32'd0);
        do_op(0, 1'b1, 2'd0, 8'h00, 1'b0, 8'hA0, 5);

        // reset asserted during ISSUE of a pop
        gnt_q.push_back(2'd0);
        @(negedge clk);
        op[0] = 1'b1; mode_req[1:0] = 2'd0; req[0] = 1'b1;
        n = 0;
        while (!st_pop && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_issue", 32'(st_pop), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_strb",  32'({st_push, st_pop}), 32'd0);
        check("midrst_done",  32'(done), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_mode",  32'(st_mode), 32'd0);
        check("midrst_en",    32'({st_en_buffer, st_en_lifo, st_en_fifo}), 32'b001);
        check("midrst_state", 32'(dbg_state), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // round-robin: all three push together, req0 stays up for a second op
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'(i % 3), 1'b0, 1'b0, 8'h00});
            gnt_q.push_back(2'(i % 3));
        end
        op = '0; mode_req = '0;
        wdata = {8'hC2, 8'hC1, 8'hC0};
        req = 3'b111;
        cnt0 = 0;
        n = 0;
        while (req != '0 && n < 60) begin
            @(negedge clk);
            n++;
            if (done[0]) begin
                cnt0++;
                if (cnt0 == 1) wdata[7:0] = 8'hC3;
                else           req[0] = 1'b0;
            end
            if (done[1]) req[1] = 1'b0;
            if (done[2]) req[2] = 1'b0;
        end
        check("rr_finished", 32'(req), 32'd0);
        for (int i = 0; i < 4; i++)
            do_op(1, 1'b1, 2'd0, 8'h00, 1'b0, 8'(8'hC0 + i), 5);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
